// File: rtl/ring_rr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ring_rr_arbiter_pkg
//   Shared definitions for the ring round-robin arbiter:
//   - state_e    : two-state arbitration FSM encoding (idle / granted)
//   - hold_width : width of the tenure-length counter for a given hold budget
// ---------------------------------------------------------------------------
package ring_rr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // Counter must reach max_hold itself; an unlimited budget (0) still needs one bit.
  function automatic int hold_width(input int max_hold);
    return (max_hold < 1) ? 1 : $clog2(max_hold + 1);
  endfunction

endpackage

// File: rtl/ring_rr_arbiter_ring_ptr.sv
// ---------------------------------------------------------------------------
// ring_rr_arbiter_ring_ptr
//   N-bit one-hot priority token register with load enable.
//   Resets asynchronously to bit 0; the arbiter loads it only at tenure end.
// Ports:
//   clk   in  1  rising-edge clock
//   clr_n in  1  asynchronous active-low reset (token -> bit 0)
//   load  in  1  capture d on the next rising edge
//   d     in  N  next token value (always one-hot from the arbiter)
//   q     out N  current token
// ---------------------------------------------------------------------------
module ring_rr_arbiter_ring_ptr #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         load,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q <= N'(1);
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ring_rr_arbiter.sv
// ---------------------------------------------------------------------------
// ring_rr_arbiter
//   Round-robin arbiter sharing one resource among N requesters. A one-hot
//   rotating token marks the highest-priority requester; the winner keeps a
//   registered one-hot grant until it drops its request or, when MAX_HOLD is
//   non-zero, until it has held the grant for MAX_HOLD cycles. Every tenure is
//   followed by one idle cycle.
// Parameters:
//   N        number of requesters (>= 2)
//   MAX_HOLD maximum consecutive grant cycles per tenure; 0 = unlimited
// Ports:
//   clk     in  1   rising-edge clock
//   clr_n   in  1   asynchronous active-low reset
//   req     in  N   level requests, held while requester wants/uses resource
//   gnt     out N   registered one-hot grant, zero when idle
//   busy    out 1   registered, equals |gnt
//   owner   out IW  index of granted requester; holds last owner when idle
//   timeout out 1   one-cycle pulse when a tenure is ended by MAX_HOLD
// ---------------------------------------------------------------------------
module ring_rr_arbiter
  import ring_rr_arbiter_pkg::*;
#(
  parameter int N        = 8,
  parameter int MAX_HOLD = 16,
  localparam int IW      = $clog2(N)
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic          busy,
  output logic [IW-1:0] owner,
  output logic          timeout
);

  localparam int            HW         = hold_width(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LIMIT = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_SAT   = '1;

  // Left-circular rotate by one: bit N-1 wraps to bit 0.
  function automatic logic [N-1:0] rotl1(input logic [N-1:0] v);
    return {v[N-2:0], v[N-1]};
  endfunction

  state_e          state;
  logic [HW-1:0]   hold_cnt;
  logic [N-1:0]    ptr;
  logic [N-1:0]    req_hi;
  logic [N-1:0]    pick_src;
  logic [N-1:0]    win;
  logic [IW-1:0]   win_idx;
  logic            release_now;
  logic            expire;
  logic            ptr_load;

  // Masked priority scan with wrap: prefer requests at or above the token;
  // if none, fall back to the lowest request overall (the wrapped part).
  // NOTE: every combinational output gets a default before any conditional
  // logic so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    req_hi   = req & ~(ptr - N'(1));
    pick_src = (|req_hi) ? req_hi : req;
    win      = pick_src & (~pick_src + N'(1));  // isolate lowest set bit
    win_idx  = '0;
    for (int i = 0; i < N; i++) begin
      if (win[i]) win_idx = IW'(i);
    end
  end

  // Release has priority over expiry; both end the tenure and advance the token.
  assign release_now = (state == ST_GRANT) && !req[owner];
  assign expire      = (state == ST_GRANT) && (MAX_HOLD != 0) && (hold_cnt == HOLD_LIMIT);
  assign ptr_load    = release_now || expire;

  ring_rr_arbiter_ring_ptr #(
    .N (N)
  ) u_ring_ptr (
    .clk   (clk),
    .clr_n (clr_n),
    .load  (ptr_load),
    .d     (rotl1(gnt)),
    .q     (ptr)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state    <= ST_IDLE;
      gnt      <= '0;
      busy     <= 1'b0;
      owner    <= '0;
      timeout  <= 1'b0;
      hold_cnt <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|req) begin
            state    <= ST_GRANT;
            gnt      <= win;
            busy     <= 1'b1;
            owner    <= win_idx;
            hold_cnt <= HW'(1);
          end
        end
        ST_GRANT: begin
          if (release_now) begin
            state <= ST_IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
          end else if (expire) begin
            state   <= ST_IDLE;
            gnt     <= '0;
            busy    <= 1'b0;
            timeout <= 1'b1;
          end else if (hold_cnt != HOLD_SAT) begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ring_rr_arbiter
//   Directed bench for ring_rr_arbiter with N=4. One instance uses
//   MAX_HOLD=4, a second uses MAX_HOLD=0 (unlimited hold). Inputs change and
//   outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_ring_rr_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          clr_n;
  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic          busy;
  logic [IW-1:0] owner;
  logic          timeout;

  logic [N-1:0]  req2;
  logic [N-1:0]  gnt2;
  logic          busy2;
  logic [IW-1:0] owner2;
  logic          timeout2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ring_rr_arbiter #(.N(N), .MAX_HOLD(4)) dut (
    .clk     (clk),
    .clr_n   (clr_n),
    .req     (req),
    .gnt     (gnt),
    .busy    (busy),
    .owner   (owner),
    .timeout (timeout)
  );

  ring_rr_arbiter #(.N(N), .MAX_HOLD(0)) dut_nh (
    .clk     (clk),
    .clr_n   (clr_n),
    .req     (req2),
    .gnt     (gnt2),
    .busy    (busy2),
    .owner   (owner2),
    .timeout (timeout2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag, input logic exp_to);
    check({tag, ".gnt"},     32'(gnt), 32'h0);
    check({tag, ".busy"},    32'(busy), 32'h0);
    check({tag, ".timeout"}, 32'(timeout), 32'(exp_to));
  endtask

  task automatic check_grant(input string tag, input logic [N-1:0] exp_g, input int exp_o);
    check({tag, ".gnt"},     32'(gnt), 32'(exp_g));
    check({tag, ".busy"},    32'(busy), 32'h1);
    check({tag, ".owner"},   32'(owner), 32'(exp_o));
    check({tag, ".timeout"}, 32'(timeout), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] fair_g [5];
    fair_g[0] = 4'b0001; fair_g[1] = 4'b0010; fair_g[2] = 4'b0100;
    fair_g[3] = 4'b1000; fair_g[4] = 4'b0001;

    // Reset held with all requests active: nothing may be granted.
    clr_n = 1'b0;
    req   = 4'b1111;
    req2  = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("reset", 1'b0);
      check("reset.owner", 32'(owner), 32'h0);
      check("reset.ptr",   32'(dut.ptr), 32'h1);
    end

    // Single requester: grant with latency 1, release moves token past it.
    req   = 4'b0000;
    clr_n = 1'b1;
    tick();
    req = 4'b0100;
    tick();
    check_grant("single.t1", 4'b0100, 2);
    tick();
    check_grant("single.t2", 4'b0100, 2);
    req = 4'b0000;
    tick();
    check_idle("single.rel", 1'b0);
    check("single.ptr", 32'(dut.ptr), 32'h8);

    // Wrap: token at bit 3, only bits 0/1 request -> bit 0 wins.
    req = 4'b0011;
    tick();
    check_grant("wrap", 4'b0001, 0);
    req = 4'b0000;
    tick();
    check_idle("wrap.rel", 1'b0);
    check("wrap.ptr", 32'(dut.ptr), 32'h2);

    // Fairness: reset between edges to restart token at bit 0, then all request.
    #2 clr_n = 1'b0;
    #1 clr_n = 1'b1;
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        check_grant($sformatf("fair%0d.c%0d", t, c), fair_g[t], (t == 4) ? 0 : t);
      end
      tick();
      check_idle($sformatf("fair%0d.gap", t), 1'b1);
    end
    req = 4'b0000;
    tick();
    check_idle("fair.pulse_end", 1'b0);
    check("fair.ptr", 32'(dut.ptr), 32'h2);

    // Timeout with one requester held 12 cycles: 4 granted, 1 gap, repeat.
    req = 4'b0001;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c % 5 == 0) check_idle($sformatf("to.c%0d", c), 1'b1);
      else            check_grant($sformatf("to.c%0d", c), 4'b0001, 0);
    end
    req = 4'b0000;
    tick();
    check_idle("to.rel", 1'b0);
    check("to.ptr", 32'(dut.ptr), 32'h2);

    // Release on the same edge the hold budget expires: no timeout pulse.
    req = 4'b0010;
    for (int c = 0; c < 4; c++) begin
      tick();
      check_grant($sformatf("relwin.c%0d", c), 4'b0010, 1);
    end
    req = 4'b0000;
    tick();
    check_idle("relwin.end", 1'b0);
    check("relwin.ptr", 32'(dut.ptr), 32'h4);

    // No preemption: other requests during a tenure are ignored.
    req = 4'b0100;
    tick();
    check_grant("nopre.t1", 4'b0100, 2);
    req = 4'b1111;
    tick();
    check_grant("nopre.t2", 4'b0100, 2);

    // Async reset mid-tenure: grant drops before the next edge.
    #2 clr_n = 1'b0;
    #1;
    check_idle("areset", 1'b0);
    check("areset.ptr", 32'(dut.ptr), 32'h1);
    clr_n = 1'b1;
    req   = 4'b1001;
    tick();
    check_grant("areset.first", 4'b0001, 0);
    req = 4'b0000;
    tick();
    check_idle("areset.rel", 1'b0);

    // Unlimited hold: one unbroken tenure, timeout never asserts.
    req2 = 4'b0001;
    for (int c = 0; c < 30; c++) begin
      tick();
      check($sformatf("nohold.gnt%0d", c), 32'(gnt2), 32'h1);
      check($sformatf("nohold.to%0d", c),  32'(timeout2), 32'h0);
    end
    check("nohold.busy", 32'(busy2), 32'h1);
    check("nohold.owner", 32'(owner2), 32'h0);
    req2 = 4'b0000;
    tick();
    check("nohold.rel", 32'(gnt2), 32'h0);
    check("nohold.rel_to", 32'(timeout2), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
